// File: rtl/pt_loader.sv
// Page table loader: copies NUM_ENTRIES 16-bit words from main memory into the paging unit.
// Optional Abort input is compiled in when PTL_ABORT_EN is defined.
module pt_loader #(
  parameter int NUM_ENTRIES = 64,
  parameter int IDX_W       = 6,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
`ifdef PTL_ABORT_EN
  input  logic              Abort,
`endif
  input  logic [ADDR_W-1:0] Base,
  output logic              Busy,
  output logic              Done,
  output logic              MReq,
  output logic [ADDR_W-1:0] MAddr,
  input  logic              MAck,
  input  logic [DATA_W-1:0] MData,
  output logic              WE,
  output logic [IDX_W-1:0]  WPTI,
  output logic [DATA_W-1:0] WPTE
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   base_q;
  logic [IDX_W-1:0]    index;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                abort_req;

`ifdef PTL_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  // Entries are 2-byte words; the sum truncates to ADDR_W so the address wraps silently.
  assign fetch_addr = base_q + ADDR_W'({index, 1'b0});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    Busy       = 1'b1;
    Done       = 1'b0;
    MReq       = 1'b0;
    WE         = 1'b0;
    MAddr      = '0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_next = FETCH;
      end
      FETCH: begin
        MReq  = 1'b1;
        MAddr = fetch_addr;
        if (abort_req) state_next = IDLE;
        else if (MAck) state_next = WRITE;
      end
      WRITE: begin
        WE = 1'b1;
        if (abort_req)              state_next = IDLE;
        else if (index == LAST_IDX) state_next = DONE;
        else                        state_next = FETCH;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      base_q <= '0;
      index  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          base_q <= Base;
          index  <= '0;
        end
        FETCH: if (MAck && !abort_req) data_q <= MData;
        WRITE: if (index != LAST_IDX) index <= index + 1'b1;
        default: ;
      endcase
    end
  end

  assign WPTI = index;
  assign WPTE = data_q;

endmodule

// File: tb/tb_pt_loader.sv
// Directed bench for pt_loader: full loads, wait states, address wrap, misuse and mid-load reset.
// The abort scenario is included when PTL_ABORT_EN is defined.
module tb_pt_loader;

  logic        Clk = 1'b0;
  logic        Rst, Start, MAck;
  logic [19:0] Base, MAddr;
  logic [15:0] MData, WPTE;
  logic        Busy, Done, MReq, WE;
  logic [5:0]  WPTI;
`ifdef PTL_ABORT_EN
  logic        Abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int we_cnt, done_cnt, done_cyc, bad_busy, bad_we, bad_hold, hold_cnt;
  logic [19:0] fetch_addr [64];

  pt_loader dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
`ifdef PTL_ABORT_EN
    .Abort (Abort),
`endif
    .Base  (Base),
    .Busy  (Busy),
    .Done  (Done),
    .MReq  (MReq),
    .MAddr (MAddr),
    .MAck  (MAck),
    .MData (MData),
    .WE    (WE),
    .WPTI  (WPTI),
    .WPTE  (WPTE)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One load: Start at cycle 0, then cycle c is sampled on the negedge inside it.
  // Memory returns 16'hA000 + word offset from base, so a wrong address shows up as wrong data.
  task automatic run_load(input logic [19:0] base, input int stall_entry, input int stall_n,
                          input bit spurious, input int restart_cyc, input int cut_entry,
                          input bit cut_abort);
    int          wait_n, cut_c, done_exp, exp_c;
    bit          finished, prev_req;
    logic [19:0] prev_addr, diff;
    wait_n = 0; cut_c = -1; done_exp = 129 + stall_n;
    finished = 1'b0; prev_req = 1'b0; prev_addr = '0;
    we_cnt = 0; done_cnt = 0; done_cyc = -1;
    bad_busy = 0; bad_we = 0; bad_hold = 0; hold_cnt = 0;

    @(negedge Clk);
    Start = 1'b1;
    Base  = base;
    for (int c = 1; c <= 400 && !finished; c++) begin
      @(negedge Clk);
      Start = (c == restart_cyc);
      Base  = ~base;
`ifdef PTL_ABORT_EN
      Abort = 1'b0;
      if (cut_abort && cut_c >= 0 && c == cut_c + 1) check("abort_busy_low", Busy, 0);
`endif
      if (!cut_abort && cut_c >= 0 && c == cut_c + 1) Rst = 1'b1;

      if (cut_c < 0 && Busy != (c <= done_exp)) bad_busy++;
      if (Done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (WE) begin
        exp_c = 2 + 2 * we_cnt + ((we_cnt >= stall_entry) ? stall_n : 0);
        if (c != exp_c || WPTI != 6'(we_cnt) || WPTE != 16'hA000 + 16'(we_cnt) || MReq)
          bad_we++;
        we_cnt++;
      end

      if (MReq) begin
        if (we_cnt < 64) fetch_addr[we_cnt] = MAddr;
        if (prev_req && MAddr != prev_addr) bad_hold++;
        if (we_cnt == stall_entry) hold_cnt++;
      end
      prev_req  = MReq;
      prev_addr = MAddr;

      if (MReq && cut_c < 0 && we_cnt == cut_entry) begin
        cut_c = c;
        if (cut_abort) begin
`ifdef PTL_ABORT_EN
          Abort = 1'b1;
`endif
        end else begin
          #1 Rst = 1'b0;
          #1 check("reset_midload_outputs", {Busy, Done, MReq, WE, MAddr, WPTI, WPTE}, '0);
        end
      end

      if (MReq && we_cnt == stall_entry && wait_n < stall_n) begin
        MAck  = 1'b0;
        MData = 16'h0;
        wait_n++;
      end else if (MReq) begin
        MAck  = 1'b1;
        diff  = MAddr - base;
        MData = 16'hA000 + 16'(diff >> 1);
      end else begin
        MAck  = spurious;
        MData = 16'hDEAD;
      end

      if (cut_c < 0 && c == done_exp + 3) finished = 1'b1;
      if (cut_c >= 0 && c == cut_c + 12) finished = 1'b1;
    end
    check("run_terminated", finished, 1);
    Start = 1'b0;
    MAck  = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; MAck = 1'b0; MData = '0; Base = '0;
`ifdef PTL_ABORT_EN
    Abort = 1'b0;
`endif
    #1 check("reset_outputs", {Busy, Done, MReq, WE, MAddr, WPTI, WPTE}, '0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("idle_busy", Busy, 0);

    // Full load, zero-wait memory.
    run_load(20'h00100, -1, 0, 1'b0, -1, -1, 1'b0);
    check("full_we_count", we_cnt, 64);
    check("full_we_seq", bad_we, 0);
    check("full_done_count", done_cnt, 1);
    check("full_done_cycle", done_cyc, 129);
    check("full_busy", bad_busy, 0);
    check("full_addr0", fetch_addr[0], 20'h00100);
    check("full_addr63", fetch_addr[63], 20'h0017E);

    // Entry 5 acknowledged after 3 wait cycles.
    run_load(20'h00100, 5, 3, 1'b0, -1, -1, 1'b0);
    check("wait_hold_cycles", hold_cnt, 4);
    check("wait_addr5", fetch_addr[5], 20'h0010A);
    check("wait_addr_stable", bad_hold, 0);
    check("wait_we_seq", bad_we, 0);
    check("wait_we_count", we_cnt, 64);
    check("wait_done_cycle", done_cyc, 132);
    check("wait_busy", bad_busy, 0);

    // Address wrap at the top of the 20-bit space.
    run_load(20'hFFFF0, -1, 0, 1'b0, -1, -1, 1'b0);
    check("wrap_addr8", fetch_addr[8], 20'h00000);
    check("wrap_addr63", fetch_addr[63], 20'h0006E);
    check("wrap_we_seq", bad_we, 0);
    check("wrap_we_count", we_cnt, 64);

    // Start re-pulsed mid-load and MAck asserted outside FETCH.
    run_load(20'h00100, -1, 0, 1'b1, 50, -1, 1'b0);
    check("misuse_we_count", we_cnt, 64);
    check("misuse_we_seq", bad_we, 0);
    check("misuse_done_count", done_cnt, 1);
    check("misuse_done_cycle", done_cyc, 129);
    check("misuse_busy", bad_busy, 0);

    // Reset during FETCH of entry 20.
    run_load(20'h00100, -1, 0, 1'b0, -1, 20, 1'b0);
    check("rst_we_count", we_cnt, 20);
    check("rst_we_seq", bad_we, 0);
    check("rst_done_count", done_cnt, 0);

    // A fresh Start after the reset reloads from index 0.
    run_load(20'h00200, -1, 0, 1'b0, -1, -1, 1'b0);
    check("reload_we_count", we_cnt, 64);
    check("reload_we_seq", bad_we, 0);
    check("reload_done_cycle", done_cyc, 129);
    check("reload_addr0", fetch_addr[0], 20'h00200);

`ifdef PTL_ABORT_EN
    // Abort during FETCH of entry 10.
    run_load(20'h00100, -1, 0, 1'b0, -1, 10, 1'b1);
    check("abort_we_count", we_cnt, 10);
    check("abort_we_seq", bad_we, 0);
    check("abort_done_count", done_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
